// File: rtl/integration_sysid_pkg.sv
// Shared definitions for the integration system-ID check.
// Contents:
//   sysid_state_e      - checker FSM states
//   SYSID_ADDR_ID/TS   - word addresses of the sysid control_slave
//   SYSID_DEFAULT_*    - expected ID/timestamp baked into the current image;
//                        the sysid slave generator uses the same constants
//   TMO_W              - width of the per-access timeout counter
package integration_sysid_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ID_REQ  = 3'd1,
    ID_WAIT = 3'd2,
    TS_REQ  = 3'd3,
    TS_WAIT = 3'd4,
    DONE    = 3'd5
  } sysid_state_e;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] SYSID_DEFAULT_ID = 32'd1395937365;
  localparam logic [31:0] SYSID_DEFAULT_TS = 32'd1539949976;

  // TIMEOUT_CYCLES is at most 65535, so the load value fits in 16 bits.
  localparam int TMO_W = 16;

endpackage

// File: rtl/integration_sysid_timeout.sv
// Per-access timeout counter for the sysid checker.
// A down-counter: loaded with (limit - 1) when an access starts, decremented
// while enabled, and expired when it reaches zero. It holds at zero rather
// than wrapping.
// Ports:
//   i_clock       system clock
//   i_reset       asynchronous active-high reset (count -> 0)
//   i_load        load i_load_value (has priority over i_en)
//   i_load_value  reload value
//   i_en          count down this cycle
//   o_expired     count is zero
module integration_sysid_timeout
  import integration_sysid_pkg::*;
(
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [TMO_W-1:0] i_load_value,
  input  logic             i_en,
  output logic             o_expired
);

  logic [TMO_W-1:0] r_count;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/integration_sysid_checker.sv
// Avalon-MM read master that checks the system-ID slave at boot.
// On start it reads word 0 (ID) and word 1 (timestamp) and compares each
// against the expected constants, reporting pass / fail / timeout.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | after reset, waiting for start
// ID_REQ  | read of word 0 presented, waiting for waitrequest low
// ID_WAIT | ID read accepted, waiting for readdatavalid
// TS_REQ  | read of word 1 presented, waiting for waitrequest low
// TS_WAIT | timestamp read accepted, waiting for readdatavalid
// DONE    | result valid and held until the next start
//
// Ports:
//   clock, reset                     clock and async active-high reset
//   start                            one-cycle pulse, honoured in IDLE/DONE
//   address, read                    Avalon request (registered)
//   waitrequest, readdata,
//   readdatavalid                    Avalon response from the interconnect
//   busy, done, pass, id_ok, ts_ok,
//   timeout                          status flags (registered)
//   id_value, ts_value               captured words
module integration_sysid_checker
  import integration_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = SYSID_DEFAULT_ID,
  parameter logic [31:0] EXPECTED_TIMESTAMP = SYSID_DEFAULT_TS,
  parameter int unsigned TIMEOUT_CYCLES     = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        address,
  output logic        read,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  input  logic        readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

  sysid_state_e r_state;
  logic         r_address;
  logic         r_read;
  logic         r_busy;
  logic         r_done;
  logic         r_pass;
  logic         r_id_ok;
  logic         r_ts_ok;
  logic         r_timeout;
  logic [31:0]  r_id_value;
  logic [31:0]  r_ts_value;

  logic w_in_req;
  logic w_in_wait;
  logic w_event;
  logic w_expired;
  logic w_abort;
  logic w_start_ok;
  logic w_load;

  assign w_in_req   = (r_state == ID_REQ)  || (r_state == TS_REQ);
  assign w_in_wait  = (r_state == ID_WAIT) || (r_state == TS_WAIT);
  // The awaited event of the current phase; it beats the limit when both
  // land in the same cycle.
  assign w_event    = (w_in_req && !waitrequest) || (w_in_wait && readdatavalid);
  assign w_abort    = (w_in_req || w_in_wait) && w_expired && !w_event;
  assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));
  // Reload on the edge that enters ID_REQ or TS_REQ, so the first cycle of
  // each access already sees the full budget.
  assign w_load     = w_start_ok || ((r_state == ID_WAIT) && readdatavalid);

  integration_sysid_timeout u_timeout (
    .i_clock      (clock),
    .i_reset      (reset),
    .i_load       (w_load),
    .i_load_value (TMO_LOAD),
    .i_en         (w_in_req || w_in_wait),
    .o_expired    (w_expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_address  <= SYSID_ADDR_ID;
      r_read     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_id_ok    <= 1'b0;
      r_ts_ok    <= 1'b0;
      r_timeout  <= 1'b0;
      r_id_value <= '0;
      r_ts_value <= '0;
    end else if (w_abort) begin
      r_state   <= DONE;
      r_read    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b1;
      r_pass    <= 1'b0;
      r_timeout <= 1'b1;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state    <= ID_REQ;
            r_address  <= SYSID_ADDR_ID;
            r_read     <= 1'b1;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_id_ok    <= 1'b0;
            r_ts_ok    <= 1'b0;
            r_timeout  <= 1'b0;
            r_id_value <= '0;
            r_ts_value <= '0;
          end
        end
        ID_REQ: begin
          if (!waitrequest) begin
            r_state <= ID_WAIT;
            r_read  <= 1'b0;
          end
        end
        ID_WAIT: begin
          if (readdatavalid) begin
            r_state    <= TS_REQ;
            r_id_value <= readdata;
            r_id_ok    <= (readdata == EXPECTED_ID);
            r_address  <= SYSID_ADDR_TS;
            r_read     <= 1'b1;
          end
        end
        TS_REQ: begin
          if (!waitrequest) begin
            r_state <= TS_WAIT;
            r_read  <= 1'b0;
          end
        end
        TS_WAIT: begin
          if (readdatavalid) begin
            r_state    <= DONE;
            r_ts_value <= readdata;
            r_ts_ok    <= (readdata == EXPECTED_TIMESTAMP);
            r_pass     <= r_id_ok && (readdata == EXPECTED_TIMESTAMP);
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_read  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign address  = r_address;
  assign read     = r_read;
  assign busy     = r_busy;
  assign done     = r_done;
  assign pass     = r_pass;
  assign id_ok    = r_id_ok;
  assign ts_ok    = r_ts_ok;
  assign timeout  = r_timeout;
  assign id_value = r_id_value;
  assign ts_value = r_ts_value;

endmodule

// File: tb/tb_integration_sysid_checker.sv
// Bench for integration_sysid_checker with a configurable Avalon slave model.
// Cycle numbering: cycle 0 is the cycle in which start is high; cycle n is
// the n-th clock period after that.
module tb_integration_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd1395937365;
  localparam logic [31:0] EXP_TS = 32'd1539949976;
  localparam int          T      = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        address;
  logic        read;
  logic        waitrequest = 1'b1;
  logic [31:0] readdata = '0;
  logic        readdatavalid = 1'b0;
  logic        busy, done, pass, id_ok, ts_ok, timeout;
  logic [31:0] id_value, ts_value;

  integration_sysid_checker #(
    .EXPECTED_ID        (EXP_ID),
    .EXPECTED_TIMESTAMP (EXP_TS),
    .TIMEOUT_CYCLES     (T)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .address       (address),
    .read          (read),
    .waitrequest   (waitrequest),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .id_ok         (id_ok),
    .ts_ok         (ts_ok),
    .timeout       (timeout),
    .id_value      (id_value),
    .ts_value      (ts_value)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clock) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Slave model: s_wait = stall cycles per word, s_lat = cycles from accept
  // to readdatavalid (0 = never answers).
  int          s_wait [2];
  int          s_lat  [2];
  logic [31:0] s_data [2];
  bit          in_req = 0;
  int          wr_left = 0;
  int          pend = 0;
  logic [31:0] pend_data = '0;
  logic        req_addr = 1'b0;
  int          acc_cnt = 0;
  bit          inj = 0;
  logic [31:0] inj_data = '0;

  always @(posedge clock) begin
    #2;
    readdatavalid = 1'b0;
    if (reset) begin
      in_req      = 0;
      pend        = 0;
      waitrequest = 1'b1;
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          readdatavalid = 1'b1;
          readdata      = pend_data;
        end
      end
      if (inj) begin
        readdatavalid = 1'b1;
        readdata      = inj_data;
      end
      if (in_req) begin
        check("stall_read", 32'(read), 32'd1);
        check("stall_addr", 32'(address), 32'(req_addr));
      end else if (read) begin
        in_req   = 1;
        req_addr = address;
        wr_left  = s_wait[address];
      end
      if (in_req) begin
        if (wr_left > 0) begin
          waitrequest = 1'b1;
          wr_left--;
        end else begin
          waitrequest = 1'b0;
          in_req      = 0;
          acc_cnt++;
          if (s_lat[req_addr] > 0) begin
            pend      = s_lat[req_addr];
            pend_data = s_data[req_addr];
          end
        end
      end else begin
        waitrequest = 1'b1;
      end
    end
  end

  typedef struct {
    logic        id_ok, ts_ok, pass, tmo;
    logic [31:0] idv, tsv;
    int          cyc;
    int          acc;
  } exp_t;

  exp_t sb[$];

  task automatic run_case(input string tag, input int wi, input int li, input int wt,
                          input int lt, input logic [31:0] idd, input logic [31:0] tsd,
                          input int poke);
    exp_t e, g;
    int   s2, c0, a0;
    bit   seen;
    e.id_ok = 0; e.ts_ok = 0; e.tmo = 0; e.idv = '0; e.tsv = '0;
    // An access starting in cycle s finishes its event in cycle s+w+l; it
    // must land no later than the counter's last cycle s+T-1.
    if (li == 0 || wi + li > T - 1) begin
      e.tmo = 1; e.cyc = 1 + T; e.acc = (wi > T - 1) ? 0 : 1;
    end else begin
      e.idv = idd; e.id_ok = (idd == EXP_ID);
      s2 = 1 + wi + li + 1;
      if (lt == 0 || wt + lt > T - 1) begin
        e.tmo = 1; e.cyc = s2 + T; e.acc = (wt > T - 1) ? 1 : 2;
      end else begin
        e.tsv = tsd; e.ts_ok = (tsd == EXP_TS); e.cyc = s2 + wt + lt + 1; e.acc = 2;
      end
    end
    e.pass = e.id_ok & e.ts_ok & ~e.tmo;
    sb.push_back(e);

    s_wait[0] = wi; s_lat[0] = li; s_data[0] = idd;
    s_wait[1] = wt; s_lat[1] = lt; s_data[1] = tsd;
    @(negedge clock);
    start = 1'b1;
    c0    = cyc;
    a0    = acc_cnt;
    seen  = 0;
    for (int n = 1; n <= 200 && !seen; n++) begin
      @(negedge clock);
      start = (n == poke);
      if (n == 1) begin
        check({tag, ":c1_read"}, 32'(read), 32'd1);
        check({tag, ":c1_addr"}, 32'(address), 32'd0);
        check({tag, ":c1_busy"}, 32'(busy), 32'd1);
        check({tag, ":c1_done"}, 32'(done), 32'd0);
        check({tag, ":c1_pass"}, 32'(pass), 32'd0);
      end
      if (done) seen = 1;
    end
    start = 1'b0;
    g = sb.pop_front();
    check({tag, ":done_seen"}, 32'(seen), 32'd1);
    check({tag, ":done_cyc"}, 32'(cyc - c0), 32'(g.cyc));
    check({tag, ":pass"}, 32'(pass), 32'(g.pass));
    check({tag, ":id_ok"}, 32'(id_ok), 32'(g.id_ok));
    check({tag, ":ts_ok"}, 32'(ts_ok), 32'(g.ts_ok));
    check({tag, ":timeout"}, 32'(timeout), 32'(g.tmo));
    check({tag, ":id_value"}, id_value, g.idv);
    check({tag, ":ts_value"}, ts_value, g.tsv);
    check({tag, ":busy"}, 32'(busy), 32'd0);
    check({tag, ":read"}, 32'(read), 32'd0);
    check({tag, ":reads"}, 32'(acc_cnt - a0), 32'(g.acc));
    repeat (3) @(negedge clock);
    check({tag, ":held_done"}, 32'(done), 32'd1);
    check({tag, ":held_id"}, id_value, g.idv);
    check({tag, ":held_id_ok"}, 32'(id_ok), 32'(g.id_ok));
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    s_wait[0] = 0; s_wait[1] = 0;
    s_lat[0]  = 1; s_lat[1]  = 1;
    s_data[0] = EXP_ID; s_data[1] = EXP_TS;
    repeat (2) @(negedge clock);
    check("rst:read", 32'(read), 32'd0);
    check("rst:address", 32'(address), 32'd0);
    check("rst:busy", 32'(busy), 32'd0);
    check("rst:done", 32'(done), 32'd0);
    check("rst:pass", 32'(pass), 32'd0);
    check("rst:id_ok", 32'(id_ok), 32'd0);
    check("rst:ts_ok", 32'(ts_ok), 32'd0);
    check("rst:timeout", 32'(timeout), 32'd0);
    check("rst:id_value", id_value, 32'd0);
    check("rst:ts_value", ts_value, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    run_case("zero_wait",  0, 1,  0, 1, EXP_ID, EXP_TS, 0);
    run_case("bad_id",     0, 1,  0, 1, 32'd0,  EXP_TS, 0);
    run_case("stall",      3, 4,  0, 1, EXP_ID, EXP_TS, 0);
    run_case("no_rdv",     0, 0,  0, 1, EXP_ID, EXP_TS, 0);
    run_case("edge_ok",    0, 15, 0, 1, EXP_ID, EXP_TS, 0);
    run_case("edge_tmo",   0, 16, 0, 1, EXP_ID, EXP_TS, 0);
    run_case("ts_stall",   0, 1,  5, 2, EXP_ID, EXP_TS, 0);
    run_case("busy_start", 0, 4,  0, 1, EXP_ID, EXP_TS, 3);
    run_case("restart",    0, 1,  0, 1, EXP_ID, 32'd7,  0);

    // Reset while the timestamp request is stalled with read high.
    s_wait[0] = 0; s_lat[0] = 1; s_data[0] = EXP_ID;
    s_wait[1] = 6; s_lat[1] = 1; s_data[1] = EXP_TS;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    check("mid:pre_read", 32'(read), 32'd1);
    check("mid:pre_addr", 32'(address), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid:read", 32'(read), 32'd0);
    check("mid:busy", 32'(busy), 32'd0);
    check("mid:address", 32'(address), 32'd0);
    check("mid:id_value", id_value, 32'd0);
    check("mid:id_ok", 32'(id_ok), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    inj      = 1;
    inj_data = EXP_ID;
    @(negedge clock);
    inj = 0;
    repeat (2) @(negedge clock);
    check("stray:id_value", id_value, 32'd0);
    check("stray:id_ok", 32'(id_ok), 32'd0);
    check("stray:done", 32'(done), 32'd0);
    check("stray:busy", 32'(busy), 32'd0);
    check("stray:read", 32'(read), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
